// File: rtl/tp_final_pkg.sv
// Shared definitions for the fetch stage: datapath width, PC step,
// FSM state encodings and a PC word-alignment helper.
package tp_final_pkg;

  localparam int ANCHO_DATO    = 32;
  localparam int INCREMENTO_PC = 4;

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    ESPERA   = 2'd1,
    RETENIDO = 2'd2
  } estado_t;

  // Instruction addresses are word aligned; the two low bits are dropped.
  function automatic logic [ANCHO_DATO-1:0] alinear(input logic [ANCHO_DATO-1:0] d);
    return {d[ANCHO_DATO-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/etapa_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and the
// instruction memory (slave).
interface etapa_fetch_if;
  import tp_final_pkg::*;

  logic                  MemReq;
  logic [ANCHO_DATO-1:0] MemDir;
  logic                  MemAck;
  logic [ANCHO_DATO-1:0] MemDato;

  modport master (output MemReq, output MemDir, input MemAck, input MemDato);
  modport slave  (input MemReq, input MemDir, output MemAck, output MemDato);
endinterface

// File: rtl/sumador_pc.sv
// Combinational PC incrementer; wraps modulo 2^32.
module sumador_pc
  import tp_final_pkg::*;
(
  input  logic [ANCHO_DATO-1:0] entrada,
  output logic [ANCHO_DATO-1:0] salida
);

  assign salida = entrada + ANCHO_DATO'(INCREMENTO_PC);

endmodule

// File: rtl/etapa_fetch.sv
// Pipeline fetch stage: drives the instruction-memory request, latches the
// returned word into the IF/ID register, and parks one word in a hold
// buffer when decode stalls at the moment memory answers.
// Optional macro FETCH_COUNT_EN adds the CuentaInstr fetched-instruction
// counter output.
module etapa_fetch
  import tp_final_pkg::*;
#(
  parameter logic [ANCHO_DATO-1:0] PC_INICIAL = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ANCHO_DATO-1:0] PcSiguiente,
  input  logic                  Stall,
  input  logic                  Flush,
  etapa_fetch_if.master         mem,
  output logic [ANCHO_DATO-1:0] Pc,
  output logic [ANCHO_DATO-1:0] PcMas4,
  output logic [ANCHO_DATO-1:0] Instr,
  output logic [ANCHO_DATO-1:0] InstrPc,
  output logic                  InstrValida
`ifdef FETCH_COUNT_EN
  ,
  output logic [ANCHO_DATO-1:0] CuentaInstr
`endif
);

  estado_t               estado;
  logic                  mem_req;
  logic [ANCHO_DATO-1:0] pc;
  logic [ANCHO_DATO-1:0] instr;
  logic [ANCHO_DATO-1:0] instr_pc;
  logic                  instr_valida;
  logic [ANCHO_DATO-1:0] buf_dato;
  logic [ANCHO_DATO-1:0] buf_pc;

  sumador_pc u_sumador (
    .entrada (pc),
    .salida  (PcMas4)
  );

  assign mem.MemReq  = mem_req;
  assign mem.MemDir  = pc;
  assign Pc          = pc;
  assign Instr       = instr;
  assign InstrPc     = instr_pc;
  assign InstrValida = instr_valida;

  // Fetch FSM: request/accept/hold sequencing plus IF/ID and PC updates.
  // Flush overrides Stall and MemAck everywhere except INICIO.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado       <= INICIO;
      mem_req      <= 1'b0;
      pc           <= PC_INICIAL;
      instr        <= '0;
      instr_pc     <= '0;
      instr_valida <= 1'b0;
      buf_dato     <= '0;
      buf_pc       <= '0;
    end else begin
      case (estado)
        INICIO: begin
          estado  <= ESPERA;
          mem_req <= 1'b1;
        end
        ESPERA: begin
          if (Flush) begin
            instr_valida <= 1'b0;
            buf_dato     <= '0;
            buf_pc       <= '0;
            pc           <= alinear(PcSiguiente);
          end else if (mem.MemAck) begin
            if (!Stall) begin
              instr        <= mem.MemDato;
              instr_pc     <= pc;
              instr_valida <= 1'b1;
              pc           <= alinear(PcSiguiente);
            end else begin
              // Decode busy: park the word and stop requesting.
              buf_dato <= mem.MemDato;
              buf_pc   <= pc;
              estado   <= RETENIDO;
              mem_req  <= 1'b0;
            end
          end else if (!Stall) begin
            instr_valida <= 1'b0;
          end
        end
        RETENIDO: begin
          if (Flush) begin
            instr_valida <= 1'b0;
            buf_dato     <= '0;
            buf_pc       <= '0;
            pc           <= alinear(PcSiguiente);
            estado       <= ESPERA;
            mem_req      <= 1'b1;
          end else if (!Stall) begin
            instr        <= buf_dato;
            instr_pc     <= buf_pc;
            instr_valida <= 1'b1;
            pc           <= alinear(PcSiguiente);
            estado       <= ESPERA;
            mem_req      <= 1'b1;
          end
        end
        default: begin
          estado  <= INICIO;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic                  nueva_instr;
  logic [ANCHO_DATO-1:0] cuenta;

  // A new instruction enters IF/ID on a stall-free accept or buffer release.
  assign nueva_instr = !Flush && !Stall &&
                       ((estado == ESPERA && mem.MemAck) || estado == RETENIDO);
  assign CuentaInstr = cuenta;

  // Fetched-instruction counter; survives Flush, wraps naturally.
  always_ff @(posedge Clk) begin
    if (Reset)            cuenta <= '0;
    else if (nueva_instr) cuenta <= cuenta + 1'b1;
  end
`endif

endmodule
